// File: rtl/i2s_transmitter.sv
// I2S master transmitter: FIFO-buffered stereo pairs, MSB-first on SDATA with generated BCLK/LRCLK.
// Latency: a queued pair plays from the next frame wrap; in_ready is low while the FIFO is full.

// Sample-pair FIFO: registered ready from the next count, head readable combinationally.
// Latency 1 clk push-to-head; push refused while full, pop on empty ignored.
module i2s_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    output logic                   push_rdy,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nx;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_comb begin
        count_nx = count;
        if (do_push && !do_pop) begin
            count_nx = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_nx = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            push_rdy <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_nx;
            push_rdy <= (count_nx != FULL);
        end
    end
endmodule

// Frame engine: divider, bit position, LRCLK/SDATA on BCLK falling edges, pop at each frame wrap.
// Outputs registered; an empty FIFO at the wrap plays a zero frame and pulses underrun.
module i2s_transmitter #(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SAMPLE_WIDTH-1:0]       in_l,
    input  logic [SAMPLE_WIDTH-1:0]       in_r,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          BCLK,
    output logic                          LRCLK,
    output logic                          SDATA,
    output logic                          frame_start,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW  = $clog2(2*SLOT_WIDTH);
    localparam int SBW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV-1);
    localparam logic [PW-1:0] P_LAST   = PW'(2*SLOT_WIDTH-1);
    localparam logic [PW-1:0] R_BEGIN  = PW'(SLOT_WIDTH);
    localparam logic [PW-1:0] L_END    = PW'(SAMPLE_WIDTH);
    localparam logic [PW-1:0] R_END    = PW'(SLOT_WIDTH+SAMPLE_WIDTH);

    logic [DW-1:0]             div_cnt;
    logic [PW-1:0]             p;
    logic [PW-1:0]             p_nx;
    logic [SAMPLE_WIDTH-1:0]   frame_l;
    logic [SAMPLE_WIDTH-1:0]   frame_r;
    logic [SBW-1:0]            l_bit;
    logic [SBW-1:0]            r_bit;
    logic [2*SAMPLE_WIDTH-1:0] head;
    logic                      div_last;
    logic                      fall;
    logic                      wrap;
    logic                      sdata_nx;
    logic                      fifo_empty;

    i2s_tx_fifo #(
        .WIDTH (2*SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (in_valid),
        .push_dat ({in_l, in_r}),
        .push_rdy (in_ready),
        .pop      (fall && wrap),
        .head_dat (head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign div_last = (div_cnt == DIV_LAST);
    assign fall     = div_last && BCLK;
    assign wrap     = (p == P_LAST);
    assign p_nx     = wrap ? '0 : p + 1'b1;

    // Each word starts one BCLK after its LRCLK edge, so position 1 carries the MSB.
    assign l_bit = SBW'(L_END - p_nx);
    assign r_bit = SBW'(R_END - p_nx);

    always_comb begin
        sdata_nx = 1'b0;
        if (p_nx != '0 && p_nx <= L_END) begin
            sdata_nx = frame_l[l_bit];
        end else if (p_nx > R_BEGIN && p_nx <= R_END) begin
            sdata_nx = frame_r[r_bit];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            BCLK        <= 1'b0;
            p           <= '0;
            LRCLK       <= 1'b0;
            SDATA       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            frame_l     <= '0;
            frame_r     <= '0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (div_last) begin
                div_cnt <= '0;
                BCLK    <= ~BCLK;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall) begin
                p     <= p_nx;
                LRCLK <= (p_nx >= R_BEGIN);
                SDATA <= sdata_nx;
                if (wrap) begin
                    frame_start <= 1'b1;
                    underrun    <= fifo_empty;
                    frame_l     <= fifo_empty ? '0 : head[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
                    frame_r     <= fifo_empty ? '0 : head[SAMPLE_WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: cycle model from closed-form timing plus table vectors and corner sequences.
module tb_i2s_transmitter;
    localparam int CD    = 2;
    localparam int SW    = 16;
    localparam int SL    = 32;
    localparam int DEPTH = 4;
    localparam int FP    = 2*CD*2*SL;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_l = '0;
    logic [15:0] in_r = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        BCLK;
    logic        LRCLK;
    logic        SDATA;
    logic        frame_start;
    logic        underrun;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad = 0;

    i2s_transmitter #(
        .CLK_DIV      (CD),
        .SAMPLE_WIDTH (SW),
        .SLOT_WIDTH   (SL),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_l        (in_l),
        .in_r        (in_r),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .BCLK        (BCLK),
        .LRCLK       (LRCLK),
        .SDATA       (SDATA),
        .frame_start (frame_start),
        .underrun    (underrun),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue of pairs, outputs derived from the number of clk edges since reset.
    pair_t       mq[$];
    pair_t       mcur;
    int unsigned mn;
    logic        m_fs;
    logic        m_ur;
    bit          live = 1'b0;

    function automatic logic [8:0] model_out();
        int   f;
        int   p;
        logic b;
        logic lr;
        logic sd;
        f  = int'(mn) / (2*CD);
        p  = f % (2*SL);
        b  = ((int'(mn) / CD) % 2) == 1;
        lr = (p >= SL);
        sd = 1'b0;
        if (p >= 1 && p <= SW) sd = mcur.l[SW-p];
        else if (p >= SL+1 && p <= SL+SW) sd = mcur.r[SL+SW-p];
        return {b, lr, sd, m_fs, m_ur, (mq.size() != DEPTH), 3'(mq.size())};
    endfunction

    initial begin
        bit rdy;
        forever begin
            @(posedge clk);
            if (reset === 1'b1) begin
                mn = 0;
                mq.delete();
                mcur = '0;
                m_fs = 1'b0;
                m_ur = 1'b0;
                live = 1'b1;
            end else if (live) begin
                rdy  = (mq.size() != DEPTH);
                mn++;
                m_fs = (mn % FP == 0);
                m_ur = 1'b0;
                if (m_fs) begin
                    if (mq.size() > 0) begin
                        mcur = mq.pop_front();
                    end else begin
                        mcur = '0;
                        m_ur = 1'b1;
                    end
                end
                if (in_valid && rdy) mq.push_back({in_l, in_r});
            end
            @(negedge clk);
            if (live) check("cycle", {BCLK, LRCLK, SDATA, frame_start, underrun, in_ready, fifo_count}, model_out());
        end
    end

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int g = 0;
        in_l = l;
        in_r = r;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && g < 4*FP) begin
            @(negedge clk);
            g++;
        end
        if (g >= 4*FP) check("push_timeout", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_frame();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (frame_start !== 1'b1 && g < 2*FP);
        if (frame_start !== 1'b1) check("frame_timeout", {63'b0, frame_start}, 64'd1);
    endtask

    // DAC view: sample SDATA/LRCLK at each BCLK rise, starting at the frame's position 0.
    task automatic capture(output logic [15:0] l, output logic [15:0] r,
                           output logic [63:0] pad, output logic [63:0] lrs);
        logic [63:0] bits;
        logic        prev;
        int          j = 0;
        int          g = 0;
        bits = '0;
        lrs  = '0;
        prev = BCLK;
        while (j < 64 && g < 2*FP) begin
            @(negedge clk);
            g++;
            if (BCLK === 1'b1 && prev === 1'b0) begin
                bits[j] = SDATA;
                lrs[j]  = LRCLK;
                j++;
            end
            prev = BCLK;
        end
        if (j < 64) check("capture_timeout", 64'(j), 64'd64);
        pad = bits;
        for (int b = 0; b < SW; b++) begin
            l[SW-1-b]  = bits[1+b];
            r[SW-1-b]  = bits[SL+1+b];
            pad[1+b]   = 1'b0;
            pad[SL+1+b] = 1'b0;
        end
    endtask

    initial begin
        vec_t        vt[5];
        pair_t       p5[5];
        pair_t       pa[3];
        logic [15:0] cl;
        logic [15:0] cr;
        logic [63:0] cpad;
        logic [63:0] clr;
        logic        pb;
        int          rise1;
        int          rise2;
        int          lrrise;
        int          k;

        vt[0] = '{16'hA5C3, 16'h0001, 16'b1010010111000011, 16'b0000000000000001};
        vt[1] = '{16'hFFFF, 16'h0000, 16'b1111111111111111, 16'b0000000000000000};
        vt[2] = '{16'h8000, 16'h7FFF, 16'b1000000000000000, 16'b0111111111111111};
        vt[3] = '{16'h0001, 16'h8000, 16'b0000000000000001, 16'b1000000000000000};
        vt[4] = '{16'h1234, 16'hFEDC, 16'b0001001000110100, 16'b1111111011011100};

        // Reset held for three clocks, then BCLK/LRCLK start-up timing.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {BCLK, LRCLK, SDATA, frame_start, underrun, in_ready, fifo_count}, 9'b000001000);
        reset = 1'b0;
        rise1 = -1;
        rise2 = -1;
        lrrise = -1;
        pb = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (BCLK === 1'b1 && pb === 1'b0) begin
                if (rise1 < 0) rise1 = c;
                else if (rise2 < 0) rise2 = c;
            end
            if (LRCLK === 1'b1 && lrrise < 0) lrrise = c;
            pb = BCLK;
        end
        check("bclk_first_rise", 64'(rise1), 64'(CD));
        check("bclk_period", 64'(rise2 - rise1), 64'(2*CD));
        check("lrclk_first_rise", 64'(lrrise), 64'(32*2*CD));

        // Table vectors; between entries the empty FIFO yields an all-zero underrun frame.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                wait_frame();
                check("ur_pulse", {63'b0, underrun}, 64'd1);
                check("ur_count", {61'b0, fifo_count}, 64'd0);
                @(negedge clk);
                check("ur_width", {63'b0, underrun}, 64'd0);
                capture(cl, cr, cpad, clr);
                check("ur_frame_bits", {cl, cr} | cpad, 64'd0);
            end
            push(vt[i].l, vt[i].r);
            wait_frame();
            check("vec_no_ur", {63'b0, underrun}, 64'd0);
            capture(cl, cr, cpad, clr);
            check("vec_l", {48'b0, cl}, {48'b0, vt[i].exp_l});
            check("vec_r", {48'b0, cr}, {48'b0, vt[i].exp_r});
            check("vec_pad", cpad, 64'd0);
            check("vec_lrclk", clr, 64'hFFFFFFFF_00000000);
        end

        // Five back-to-back pushes: fourth fills, fifth waits for the next pop.
        wait_frame();
        for (int i = 0; i < 5; i++) p5[i] = {16'($urandom), 16'($urandom)};
        for (int i = 0; i < 4; i++) push(p5[i].l, p5[i].r);
        check("full_rdy", {63'b0, in_ready}, 64'd0);
        check("full_cnt", {61'b0, fifo_count}, 64'd4);
        push(p5[4].l, p5[4].r);
        check("refill_cnt", {61'b0, fifo_count}, 64'd4);
        check("refill_rdy", {63'b0, in_ready}, 64'd0);
        for (int i = 1; i < 5; i++) begin
            wait_frame();
            capture(cl, cr, cpad, clr);
            check("order_pair", {32'b0, cl, cr}, {32'b0, p5[i]});
        end

        // Same-cycle push and pop with two queued.
        wait_frame();
        for (int i = 0; i < 3; i++) pa[i] = {16'($urandom), 16'($urandom)};
        push(pa[0].l, pa[0].r);
        push(pa[1].l, pa[1].r);
        repeat (FP-3) @(negedge clk);
        check("pp_pre_cnt", {61'b0, fifo_count}, 64'd2);
        in_l = pa[2].l;
        in_r = pa[2].r;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("pp_fs", {63'b0, frame_start}, 64'd1);
        check("pp_cnt", {61'b0, fifo_count}, 64'd2);
        capture(cl, cr, cpad, clr);
        check("pp_oldest", {32'b0, cl, cr}, {32'b0, pa[0]});
        for (int i = 1; i < 3; i++) begin
            wait_frame();
            capture(cl, cr, cpad, clr);
            check("pp_next", {32'b0, cl, cr}, {32'b0, pa[i]});
        end

        // Reset in the right slot with three pairs queued.
        wait_frame();
        for (int i = 0; i < 4; i++) push(16'($urandom), 16'($urandom));
        wait_frame();
        repeat (40*2*CD) @(negedge clk);
        check("mid_lrclk", {63'b0, LRCLK}, 64'd1);
        check("mid_cnt", {61'b0, fifo_count}, 64'd3);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", {55'b0, BCLK, LRCLK, SDATA, frame_start, underrun, in_ready, fifo_count},
              64'b000001000);
        reset = 1'b0;
        k = 0;
        for (int c = 1; c < FP; c++) begin
            @(negedge clk);
            if (underrun !== 1'b0 || frame_start !== 1'b0) k++;
        end
        check("post_rst_quiet", 64'(k), 64'd0);
        wait_frame();
        check("post_rst_ur", {63'b0, underrun}, 64'd1);

        // Random traffic: heavy phase exercises backpressure, light phase exercises underrun.
        for (int c = 0; c < 12000; c++) begin
            in_valid = ($urandom_range(0, 999) < ((c < 6000) ? 20 : 3));
            in_l = 16'($urandom);
            in_r = 16'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
